acorn128_ctrl: RTL and testbench
================================

ACORN128_CTRL -- requirements
Module: acorn128_ctrl

Interface
REQ-001 Parameter LEN_W, default 16, width of bit-length inputs.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  begins one AEAD operation; sampled only in IDLE.
REQ-005 ad_len  input  LEN_W  associated-data length in bits; captured on accepted start.
REQ-006 msg_len  input  LEN_W  plaintext length in bits; captured on accepted start.
REQ-007 din_valid  input  1  din carries the next AD or plaintext bit.
REQ-008 din_ready  output  1  controller consumes din this cycle.
REQ-009 step_en  output  1  datapath performs one state-update step this cycle.
REQ-010 ca  output  1  ca control bit for this step.
REQ-011 cb  output  1  cb control bit for this step.
REQ-012 msel  output  3  message-bit source: 0 zero, 1 one, 2 key[kidx], 3 key[kidx]^1, 4 iv[kidx], 5 din.
REQ-013 kidx  output  7  key/IV bit index for msel 2-4.
REQ-014 ct_valid  output  1  ciphertext bit (din ^ keystream) valid this step.
REQ-015 tag_valid  output  1  keystream bit of this step is a tag bit.
REQ-016 phase  output  3  0 IDLE, 1 INIT, 2 AD, 3 ENC, 4 FIN, 5 DONE.
REQ-017 busy  output  1  phase not IDLE.
REQ-018 done  output  1  one-cycle pulse on entering DONE.

Function
REQ-019 FSM IDLE->INIT->AD->ENC->FIN->DONE->IDLE; a step counter cnt (LEN_W+1 bits) restarts at 0 on every phase entry.
REQ-020 IDLE: start=1 captures lengths, next cycle INIT, cnt=0; start ignored in all other phases.
REQ-021 INIT: 1792 steps, step_en=1 every cycle, ca=cb=1; cnt 0-127 msel=2, 128-255 msel=4, 256 msel=3, 257-1791 msel=2; kidx=cnt[6:0].
REQ-022 AD: ad_len+256 steps; cb=1 all steps; ca=1 while cnt<ad_len+128, else 0.
REQ-023 AD data steps (cnt<ad_len): msel=5, din_ready=1, step_en=din_valid, cnt advances only on din_valid; stall holds all outputs except step_en/din_ready.
REQ-024 AD cnt==ad_len msel=1; cnt>ad_len msel=0; these steps never stall.
REQ-025 ENC: msg_len+256 steps; cb=0; ca=1 while cnt<msg_len+128; msel/handshake as REQ-023/024 using msg_len; ct_valid=step_en on data steps.
REQ-026 FIN: 768 steps, ca=cb=1, msel=0, step_en=1; tag_valid=1 for cnt 640-767 (128 tag bits, LSB first).
REQ-027 DONE: one cycle, done=1, step_en=0, then IDLE.
REQ-028 ad_len=0 or msg_len=0: phase starts at the padding-1 step, no din_ready asserted.
REQ-029 Transition on the cycle after the last step; no idle gap: last INIT step then first AD step consecutive.
REQ-030 din_ready=0 outside data steps; din_valid then ignored.
REQ-031 Lengths held internally; changes on inputs mid-operation have no effect.
REQ-032 Total steps = 1792+ad_len+256+msg_len+256+768.

Reset
REQ-033 rst=0 asynchronously forces phase=IDLE, cnt=0, captured lengths=0, all outputs 0.
REQ-034 rst asserted mid-operation aborts; after release block waits in IDLE for start; no partial done.

Verification
REQ-035 ad_len=0, msg_len=0, din_valid=1: start -> step_en high 3072 consecutive cycles, tag_valid on last 128, done 1 cycle after.
REQ-036 INIT check: cnt 0/128/256/257 -> msel 2/4/3/2, kidx 0/0/0/1, ca=cb=1 throughout.
REQ-037 ad_len=8, msg_len=16, din_valid toggling 1/0: step_en only with din_valid on data steps; ct_valid count=16; AD ca falls after step 136.
REQ-038 msg_len=128 with din_valid held 0 for 50 cycles at ENC step 5 -> cnt frozen, outputs stable, resumes on valid.
REQ-039 rst low at FIN step 300 -> outputs 0 immediately, phase IDLE, no done; new start runs full sequence.
REQ-040 start pulsed during AD -> ignored; sequence length unchanged.

Source files
------------

// File: rtl/acorn128_ctrl.sv
// ACORN-128 AEAD step controller: sequences INIT, AD, ENC and FIN state-update
// steps and tells the datapath which message bit and control bits to use.
module acorn128_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] ad_len,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             step_en,
    output logic             ca,
    output logic             cb,
    output logic [2:0]       msel,
    output logic [6:0]       kidx,
    output logic             ct_valid,
    output logic             tag_valid,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             done
);

    localparam int CW = LEN_W + 1;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_INIT = 3'd1,
        PH_AD   = 3'd2,
        PH_ENC  = 3'd3,
        PH_FIN  = 3'd4,
        PH_DONE = 3'd5
    } phase_e;

    localparam logic [2:0] MSEL_ZERO = 3'd0;
    localparam logic [2:0] MSEL_ONE  = 3'd1;
    localparam logic [2:0] MSEL_KEY  = 3'd2;
    localparam logic [2:0] MSEL_NKEY = 3'd3;
    localparam logic [2:0] MSEL_IV   = 3'd4;
    localparam logic [2:0] MSEL_DIN  = 3'd5;

    phase_e           phase_q, phase_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0] ad_len_q, ad_len_d;
    logic [LEN_W-1:0] msg_len_q, msg_len_d;

    // AD and ENC share one step layout, parameterised by the active length.
    logic [CW-1:0] len_ext;
    logic          data_step;
    logic          ca_window;
    logic          pad_last;

    always_comb begin
        len_ext   = (phase_q == PH_AD) ? {1'b0, ad_len_q} : {1'b0, msg_len_q};
        data_step = (cnt_q < len_ext);
        ca_window = (cnt_q < len_ext + CW'(128));
        pad_last  = (cnt_q == len_ext + CW'(255));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q   <= PH_IDLE;
            cnt_q     <= '0;
            ad_len_q  <= '0;
            msg_len_q <= '0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            ad_len_q  <= ad_len_d;
            msg_len_q <= msg_len_d;
        end
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        ad_len_d  = ad_len_q;
        msg_len_d = msg_len_q;
        unique case (phase_q)
            PH_IDLE: begin
                if (start) begin
                    ad_len_d  = ad_len;
                    msg_len_d = msg_len;
                    phase_d   = PH_INIT;
                    cnt_d     = '0;
                end
            end
            PH_INIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(1791)) begin
                    phase_d = PH_AD;
                    cnt_d   = '0;
                end
            end
            PH_AD, PH_ENC: begin
                if (step_en) begin
                    cnt_d = cnt_q + CW'(1);
                    if (pad_last) begin
                        phase_d = (phase_q == PH_AD) ? PH_ENC : PH_FIN;
                        cnt_d   = '0;
                    end
                end
            end
            PH_FIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(767)) begin
                    phase_d = PH_DONE;
                    cnt_d   = '0;
                end
            end
            default: begin
                phase_d = PH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        din_ready = 1'b0;
        step_en   = 1'b0;
        ca        = 1'b0;
        cb        = 1'b0;
        msel      = MSEL_ZERO;
        kidx      = 7'd0;
        ct_valid  = 1'b0;
        tag_valid = 1'b0;
        done      = 1'b0;
        phase     = phase_q;
        busy      = (phase_q != PH_IDLE);
        unique case (phase_q)
            PH_INIT: begin
                step_en = 1'b1;
                ca      = 1'b1;
                cb      = 1'b1;
                kidx    = cnt_q[6:0];
                if (cnt_q < CW'(128))       msel = MSEL_KEY;
                else if (cnt_q < CW'(256))  msel = MSEL_IV;
                else if (cnt_q == CW'(256)) msel = MSEL_NKEY;
                else                        msel = MSEL_KEY;
            end
            PH_AD, PH_ENC: begin
                cb = (phase_q == PH_AD);
                ca = ca_window;
                if (data_step) begin
                    msel      = MSEL_DIN;
                    din_ready = 1'b1;
                    step_en   = din_valid;
                    ct_valid  = (phase_q == PH_ENC) && din_valid;
                end else begin
                    msel    = (cnt_q == len_ext) ? MSEL_ONE : MSEL_ZERO;
                    step_en = 1'b1;
                end
            end
            PH_FIN: begin
                step_en   = 1'b1;
                ca        = 1'b1;
                cb        = 1'b1;
                tag_valid = (cnt_q >= CW'(640));
            end
            PH_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_acorn128_ctrl.sv
// Self-checking bench for acorn128_ctrl: a step-list reference model of each
// operation, table-driven length/handshake vectors, and reset/stall/start corners.
module tb_acorn128_ctrl;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] ad_len = '0;
    logic [LEN_W-1:0] msg_len = '0;
    logic             din_valid = 1'b0;
    logic             din_ready, step_en, ca, cb, ct_valid, tag_valid, busy, done;
    logic [2:0]       msel, phase;
    logic [6:0]       kidx;

    acorn128_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .ad_len(ad_len), .msg_len(msg_len),
        .din_valid(din_valid), .din_ready(din_ready), .step_en(step_en), .ca(ca),
        .cb(cb), .msel(msel), .kidx(kidx), .ct_valid(ct_valid), .tag_valid(tag_valid),
        .phase(phase), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // One entry per state-update step of an operation, in execution order.
    typedef struct {
        int ph;
        int idx;
        bit ca;
        bit cb;
        int msel;
        bit data;
        bit ct;
        bit tag;
    } step_t;

    step_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void push_step(int ph, int idx, bit a, bit b, int ms, bit data, bit ct, bit tag);
        step_t s;
        s.ph = ph; s.idx = idx; s.ca = a; s.cb = b; s.msel = ms;
        s.data = data; s.ct = ct; s.tag = tag;
        exp_q.push_back(s);
    endfunction

    function automatic void build_model(int ad, int ml);
        int ms;
        exp_q.delete();
        for (int i = 0; i < 1792; i++) begin
            ms = (i < 128) ? 2 : (i < 256) ? 4 : (i == 256) ? 3 : 2;
            push_step(1, i, 1, 1, ms, 0, 0, 0);
        end
        for (int i = 0; i < ad + 256; i++)
            push_step(2, i, i < ad + 128, 1, (i < ad) ? 5 : (i == ad) ? 1 : 0, i < ad, 0, 0);
        for (int i = 0; i < ml + 256; i++)
            push_step(3, i, i < ml + 128, 0, (i < ml) ? 5 : (i == ml) ? 1 : 0, i < ml, i < ml, 0);
        for (int i = 0; i < 768; i++)
            push_step(4, i, 1, 1, 0, 0, 0, i >= 640);
    endfunction

    function automatic logic [20:0] pack_act();
        logic [6:0] k;
        k = (msel >= 3'd2 && msel <= 3'd4) ? kidx : 7'd0;
        return {phase, busy, done, step_en, din_ready, ca, cb, msel, k, ct_valid, tag_valid};
    endfunction

    function automatic logic [20:0] pack_exp(step_t s, bit dv);
        logic [6:0] k;
        bit         se;
        k  = (s.msel >= 2 && s.msel <= 4) ? 7'(s.idx % 128) : 7'd0;
        se = s.data ? dv : 1'b1;
        return {3'(s.ph), 1'b1, 1'b0, se, s.data, s.ca, s.cb, 3'(s.msel), k, s.ct && dv, s.tag};
    endfunction

    localparam logic [20:0] DONE_OUT = {3'd5, 1'b1, 1'b1, 16'd0};

    // mode: 0 valid held high, 1 toggling, 2 random, 3 fifty-cycle stall at ENC step 5
    task automatic run_op(input int ad, input int ml, input int mode, input int abort_fin,
                          input bit poke, output int n_step, output int n_ct,
                          output int n_tag, output int n_stall, output bit aborted);
        step_t       s;
        int          budget;
        bit          ok, dv, tog;
        logic [20:0] got, exp;
        build_model(ad, ml);
        n_step = 0; n_ct = 0; n_tag = 0; n_stall = 0; aborted = 0; ok = 1; tog = 1;
        budget = exp_q.size() * 3 + 200;
        @(posedge clk); #1;
        start = 1'b1; ad_len = LEN_W'(ad); msg_len = LEN_W'(ml);
        while (exp_q.size() > 0 && budget > 0 && ok && !aborted) begin
            @(posedge clk); #1;
            budget--;
            s = exp_q[0];
            start   = poke && s.ph == 2 && s.idx == 3;
            ad_len  = LEN_W'($urandom);
            msg_len = LEN_W'($urandom);
            case (mode)
                0: dv = 1'b1;
                1: begin dv = tog; tog = ~tog; end
                2: dv = 1'($urandom_range(0, 1));
                default: begin
                    dv = !(s.ph == 3 && s.idx == 5 && n_stall < 50);
                    if (!dv) n_stall++;
                end
            endcase
            din_valid = dv;
            @(negedge clk);
            got = pack_act();
            exp = pack_exp(s, dv);
            ok  = (got === exp);
            check($sformatf("step ph%0d idx%0d", s.ph, s.idx), 32'(got), 32'(exp));
            if (step_en)   n_step++;
            if (ct_valid)  n_ct++;
            if (tag_valid) n_tag++;
            if (abort_fin >= 0 && s.ph == 4 && s.idx == abort_fin) aborted = 1;
            else if (!s.data || dv) void'(exp_q.pop_front());
        end
        start = 1'b0;
        if (ok && !aborted) begin
            check("step budget", 32'(exp_q.size()), 32'd0);
            @(posedge clk); #1 din_valid = 1'b0;
            @(negedge clk);
            check("done cycle", 32'(pack_act()), 32'(DONE_OUT));
            @(posedge clk); #1;
            @(negedge clk);
            check("back to idle", 32'(pack_act()), 32'd0);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk); #2 rst = 1'b0;
        #1 check("async reset outputs", 32'(pack_act()), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    typedef struct {
        int ad;
        int ml;
        int mode;
        int exp_steps;
        int exp_ct;
        int exp_tag;
    } vec_t;

    typedef struct {
        int cnt;
        int msel;
        int kidx;
    } init_vec_t;

    int        n_step, n_ct, n_tag, n_stall;
    bit        aborted;
    vec_t      vecs[5];
    init_vec_t ivecs[7];

    initial begin
        vecs[0] = '{0, 0, 0, 3072, 0, 128};
        vecs[1] = '{8, 16, 1, 3096, 16, 128};
        vecs[2] = '{1, 0, 2, 3073, 0, 128};
        vecs[3] = '{0, 3, 2, 3075, 3, 128};
        vecs[4] = '{5, 5, 0, 3082, 5, 128};
        ivecs[0] = '{0, 2, 0};
        ivecs[1] = '{127, 2, 127};
        ivecs[2] = '{128, 4, 0};
        ivecs[3] = '{255, 4, 127};
        ivecs[4] = '{256, 3, 0};
        ivecs[5] = '{257, 2, 1};
        ivecs[6] = '{1791, 2, 127};

        #12 check("reset state", 32'(pack_act()), 32'd0);
        #10 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle after reset", 32'(pack_act()), 32'd0);
        end

        foreach (vecs[v]) begin
            run_op(vecs[v].ad, vecs[v].ml, vecs[v].mode, -1, 0, n_step, n_ct, n_tag, n_stall, aborted);
            check($sformatf("vec%0d step count", v), 32'(n_step), 32'(vecs[v].exp_steps));
            check($sformatf("vec%0d ct count", v), 32'(n_ct), 32'(vecs[v].exp_ct));
            check($sformatf("vec%0d tag count", v), 32'(n_tag), 32'(vecs[v].exp_tag));
        end

        // INIT key/IV schedule spot checks, then abort with reset.
        @(posedge clk); #1 start = 1'b1; din_valid = 1'b1;
        for (int i = 0; i < 1792; i++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            foreach (ivecs[j])
                if (ivecs[j].cnt == i)
                    check($sformatf("init cnt %0d msel/kidx/ca/cb", i),
                          {phase, msel, kidx, ca, cb},
                          {3'd1, 3'(ivecs[j].msel), 7'(ivecs[j].kidx), 2'b11});
        end
        reset_dut();

        // Long din stall in the middle of ENC.
        run_op(0, 128, 3, -1, 0, n_step, n_ct, n_tag, n_stall, aborted);
        check("stall length", 32'(n_stall), 32'd50);
        check("stall ct count", 32'(n_ct), 32'd128);

        // Start pulsed during AD must not disturb the sequence.
        run_op(8, 4, 0, -1, 1, n_step, n_ct, n_tag, n_stall, aborted);
        check("poke step count", 32'(n_step), 32'd3084);

        // Reset in the middle of FIN: abort, no done, then a clean full run.
        run_op(4, 4, 0, 300, 0, n_step, n_ct, n_tag, n_stall, aborted);
        check("fin abort reached", 32'(aborted), 32'd1);
        reset_dut();
        repeat (5) begin
            @(negedge clk);
            check("idle after abort", {phase, busy, done}, 5'd0);
        end
        run_op(4, 4, 2, -1, 0, n_step, n_ct, n_tag, n_stall, aborted);
        check("rerun step count", 32'(n_step), 32'd3080);

        // Random lengths and handshake against the step-list model.
        repeat (4) begin
            int ad, ml;
            ad = $urandom_range(0, 40);
            ml = $urandom_range(0, 40);
            run_op(ad, ml, 2, -1, 1'($urandom_range(0, 1)), n_step, n_ct, n_tag, n_stall, aborted);
            check("rand step count", 32'(n_step), 32'(3072 + ad + ml));
            check("rand ct count", 32'(n_ct), 32'(ml));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
